nios_reset_sequencer: RTL and testbench

Sequences the reset of the fluid-board Nios core from several sources: software request (PIO reset output), watchdog timeout, external reset input and power-on. Guarantees a minimum reset pulse width, waits for PLL lock and a release hold-off, then releases nios_reset_n. Status is exposed on a 4-word Avalon-MM slave on the supervisor bus.

---
 rtl/nios_reset_pkg.sv | 25 ++
 rtl/nios_reset_sequencer_if.sv | 11 +
 rtl/reset_sync2.sv | 25 ++
 rtl/nios_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_nios_reset_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/nios_reset_pkg.sv
// Shared definitions for the Nios reset sequencer: FSM state codes, register map
// and status/cause bit positions.
package nios_reset_pkg;

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StAssert   = 3'd1,
    StWaitLock = 3'd2,
    StHoldoff  = 3'd3
  } state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;
  localparam logic [1:0] AddrRsvd   = 2'd3;

  localparam int unsigned StatusLockBit  = 3;
  localparam int unsigned StatusCauseLsb = 8;

  localparam int unsigned CausePor = 0;
  localparam int unsigned CauseSw  = 1;
  localparam int unsigned CauseWdt = 2;
  localparam int unsigned CauseExt = 3;

endpackage

// File: rtl/nios_reset_sequencer_if.sv
// Avalon-MM slave bundle for the reset sequencer status registers.
interface nios_reset_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/reset_sync2.sv
// Two-flop synchroniser with asynchronous clear to a chosen level.
module reset_sync2 #(
  parameter logic ClearVal = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= ClearVal;
      sync_q <= ClearVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nios_reset_sequencer.sv
// Sequences the Nios core reset from software, watchdog, board and power-on sources,
// enforcing a minimum pulse, PLL lock and a release hold-off. Status on an Avalon slave.
module nios_reset_sequencer
  import nios_reset_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 1000,
  parameter int unsigned HOLDOFF_CYCLES = 100,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nios_reset_sequencer_if.slave        avs,
  input  logic                         sw_reset_req,
  input  logic                         wdt_timeout,
  input  logic                         ext_reset_n,
  input  logic                         pll_locked,
  output logic                         nios_reset_n,
  output logic                         busy
);

  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      count_q, count_d;
  logic [3:0]       cause_q, cause_d, cause_set, cause_clr;
  logic             sw_q, nios_q, nios_d;
  logic             ext_sync, lock_sync;
  logic             wr, ctrl_req, sw_rise, ext_trig, trig, inc, count_clr;
  logic             unused_wdata;

  reset_sync2 #(.ClearVal(1'b1)) u_ext_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ext_reset_n),
    .q       (ext_sync)
  );

  reset_sync2 #(.ClearVal(1'b0)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_sync)
  );

  assign wr        = avs.chipselect && !avs.write_n;
  assign ctrl_req  = wr && (avs.address == AddrCtrl) && avs.writedata[0];
  assign count_clr = wr && (avs.address == AddrCount);
  assign sw_rise   = sw_reset_req && !sw_q;
  assign ext_trig  = !ext_sync;
  assign trig      = sw_rise || wdt_timeout || ext_trig || ctrl_req;

  assign unused_wdata = ^{avs.writedata[31:12], avs.writedata[7:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (trig) begin
          state_d = StAssert;
          cnt_d   = '0;
          inc     = 1'b1;
        end
      end
      StAssert: begin
        if (trig) begin
          cnt_d = '0;
        end else if (cnt_q == PulseLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (trig) begin
          state_d = StAssert;
          cnt_d   = '0;
        end else if (lock_sync) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end
      end
      StHoldoff: begin
        if (trig) begin
          state_d = StAssert;
          cnt_d   = '0;
        end else if (!lock_sync) begin
          state_d = StWaitLock;
        end else if (cnt_q == HoldoffLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StAssert;
        cnt_d   = '0;
      end
    endcase
  end

  // Release only after a full cycle in RUN; drop on the edge that leaves RUN.
  assign nios_d = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    cause_set           = '0;
    cause_set[CauseSw]  = sw_rise || ctrl_req;
    cause_set[CauseWdt] = wdt_timeout;
    cause_set[CauseExt] = ext_trig;
    cause_clr = (wr && (avs.address == AddrStatus)) ?
                avs.writedata[StatusCauseLsb +: 4] : 4'd0;
    cause_d   = (cause_q & ~cause_clr) | cause_set;
  end

  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = inc ? 16'd1 : 16'd0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      nios_q  <= 1'b0;
      cause_q <= 4'(1 << CausePor);
      count_q <= '0;
      sw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nios_q  <= nios_d;
      cause_q <= cause_d;
      count_q <= count_d;
      sw_q    <= sw_reset_req;
    end
  end

  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      AddrStatus: begin
        avs.readdata[2:0]                     = state_q;
        avs.readdata[StatusLockBit]           = lock_sync;
        avs.readdata[StatusCauseLsb +: 4]     = cause_q;
      end
      AddrCount: avs.readdata[15:0] = count_q;
      AddrCtrl, AddrRsvd: avs.readdata = '0;
      default: avs.readdata = '0;
    endcase
  end

  assign nios_reset_n = nios_q;
  assign busy         = (state_q != StRun);

endmodule

// File: tb/tb_nios_reset_sequencer.sv
// Scoreboard bench for nios_reset_sequencer: low-time and register expectations are
// queued with the stimulus and popped when the DUT responds.
module tb_nios_reset_sequencer;
  import nios_reset_pkg::*;

  localparam int unsigned Pulse   = 4;
  localparam int unsigned Holdoff = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sw_reset_req = 1'b0;
  logic wdt_timeout = 1'b0;
  logic ext_reset_n = 1'b1;
  logic pll_locked = 1'b1;
  logic nios_reset_n, busy;

  nios_reset_sequencer_if bus ();

  nios_reset_sequencer #(
    .PULSE_CYCLES   (Pulse),
    .HOLDOFF_CYCLES (Holdoff),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs          (bus.slave),
    .sw_reset_req (sw_reset_req),
    .wdt_timeout  (wdt_timeout),
    .ext_reset_n  (ext_reset_n),
    .pll_locked   (pll_locked),
    .nios_reset_n (nios_reset_n),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] low_q[$];
  logic [31:0] rd_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input state_e st, input logic lock,
                                              input logic [3:0] cause);
    logic [31:0] w;
    w        = '0;
    w[2:0]   = st;
    w[3]     = lock;
    w[11:8]  = cause;
    return w;
  endfunction

  task automatic pop_check(input string tag, input logic [31:0] got, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected <empty scoreboard>", tag, got);
    end else begin
      check_eq(tag, got, q.pop_front());
    end
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    bus.address = a;
    #1;
    pop_check(tag, bus.readdata, rd_q);
  endtask

  task automatic read_state(input state_e st, input string tag);
    rd_q.push_back({29'd0, st});
    bus.address = AddrStatus;
    #1;
    pop_check(tag, {29'd0, bus.readdata[2:0]}, rd_q);
  endtask

  task automatic bus_write_start(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_write_start(a, d);
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Counts clock edges after which nios_reset_n is still low; injects events by count.
  task automatic measure_low(input string tag, input int wdt_at, input int drop_at,
                             input int rise_at, input int peek_at, input state_e peek_st);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(posedge clk);
      #1;
      wdt_timeout    = 1'b0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      if (nios_reset_n) begin
        done = 1'b1;
      end else begin
        n++;
        if (n == wdt_at)  wdt_timeout = 1'b1;
        if (n == drop_at) pll_locked  = 1'b0;
        if (n == rise_at) pll_locked  = 1'b1;
        if (n == peek_at) read_state(peek_st, {tag, "_peek"});
      end
    end
    pop_check({tag, "_low"}, 32'(n), low_q);
  endtask

  initial begin
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_nios", {31'd0, nios_reset_n}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    bus_read(AddrStatus, status_word(StAssert, 1'b0, 4'b0001), "rst_status");
    bus_read(AddrCount, 32'd0, "rst_count");

    // Power-on: already in ASSERT at release, lock syncs during the pulse.
    low_q.push_back(Pulse + Holdoff + 1);
    @(negedge clk);
    reset_n = 1'b1;
    measure_low("por", 0, 0, 0, 0, StRun);
    @(negedge clk);
    check_eq("por_busy", {31'd0, busy}, 32'd0);
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b0001), "por_status");
    bus_read(AddrCount, 32'd0, "por_count");

    // SW request from RUN, watchdog retrigger at ASSERT counter 2.
    low_q.push_back(3 + Pulse + Holdoff + 2);
    @(negedge clk);
    sw_reset_req = 1'b1;
    measure_low("retrig", 3, 0, 0, 0, StRun);
    @(negedge clk);
    bus_read(AddrCount, 32'd1, "retrig_count");
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b0111), "retrig_status");
    repeat (20) @(negedge clk);
    check_eq("sw_level_held", {31'd0, nios_reset_n}, 32'd1);
    bus_read(AddrCount, 32'd1, "sw_held_count");
    sw_reset_req = 1'b0;

    // W1C of the POR cause only.
    bus_write(AddrStatus, 32'h100);
    @(negedge clk);
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b0110), "w1c_por");

    // CTRL request with lock loss in HOLDOFF, lock back after 16 low edges.
    low_q.push_back(16 + 2 + 1 + Holdoff);
    @(negedge clk);
    bus_write_start(AddrCtrl, 32'd1);
    measure_low("lockloss", 0, 6, 16, 12, StWaitLock);
    @(negedge clk);
    bus_read(AddrCtrl, 32'd0, "ctrl_reads0");
    bus_read(AddrCount, 32'd2, "ctrl_count");
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b0110), "ctrl_status");

    // COUNT clear coincident with a RUN->ASSERT trigger.
    low_q.push_back(Pulse + Holdoff + 2);
    @(negedge clk);
    wdt_timeout = 1'b1;
    bus_write_start(AddrCount, 32'h1234);
    measure_low("cntclr", 0, 0, 0, 0, StRun);
    @(negedge clk);
    bus_read(AddrCount, 32'd1, "cntclr_count");

    // Clear-all cause write coincident with a watchdog set: the set survives.
    low_q.push_back(Pulse + Holdoff + 2);
    @(negedge clk);
    wdt_timeout = 1'b1;
    bus_write_start(AddrStatus, 32'hF00);
    measure_low("w1c_set", 0, 0, 0, 0, StRun);
    @(negedge clk);
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b0100), "w1c_set_status");
    bus_read(AddrCount, 32'd2, "w1c_set_count");

    // Board reset held low for 50 cycles.
    @(negedge clk);
    ext_reset_n = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 9) read_state(StAssert, "ext_hold");
    end
    ext_reset_n = 1'b1;
    for (int j = 1; j <= int'(2 + Pulse); j++) begin
      @(posedge clk);
      #1;
      if (j == int'(1 + Pulse)) read_state(StAssert, "ext_rel_assert");
      if (j == int'(2 + Pulse)) read_state(StWaitLock, "ext_rel_waitlock");
    end
    low_q.push_back(Holdoff + 1);
    measure_low("ext_tail", 0, 0, 0, 0, StRun);
    @(negedge clk);
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b1100), "ext_status");
    bus_read(AddrCount, 32'd3, "ext_count");

    // Reserved address.
    bus_write(AddrRsvd, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_read(AddrRsvd, 32'd0, "rsvd_read");
    bus_read(AddrCount, 32'd3, "rsvd_count");
    bus_read(AddrStatus, status_word(StRun, 1'b1, 4'b1100), "rsvd_status");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
